// File: rtl/rf_wb_arbiter_if.sv
// Writeback request, register-file write port and forwarding lookup signals
// of the register-file writeback arbiter.
interface rf_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              req0_valid;
   logic [ADDR_W-1:0] req0_addr;
   logic [DATA_W-1:0] req0_data;
   logic              req0_ready;
   logic              req1_valid;
   logic [ADDR_W-1:0] req1_addr;
   logic [DATA_W-1:0] req1_data;
   logic              req1_ready;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [ADDR_W-1:0] fwd_raddr1;
   logic              fwd_hit1;
   logic [DATA_W-1:0] fwd_data1;
   logic [ADDR_W-1:0] fwd_raddr2;
   logic              fwd_hit2;
   logic [DATA_W-1:0] fwd_data2;
   logic [7:0]        busy_cnt;

   // Requesters, readers and the register file form the master side.
   modport master (
      output req0_valid, req0_addr, req0_data, input req0_ready,
      output req1_valid, req1_addr, req1_data, input req1_ready,
      input  rf_we, rf_waddr, rf_wdata,
      output fwd_raddr1, input fwd_hit1, fwd_data1,
      output fwd_raddr2, input fwd_hit2, fwd_data2,
      input  busy_cnt
   );

   modport slave (
      input  req0_valid, req0_addr, req0_data, output req0_ready,
      input  req1_valid, req1_addr, req1_data, output req1_ready,
      output rf_we, rf_waddr, rf_wdata,
      input  fwd_raddr1, output fwd_hit1, fwd_data1,
      input  fwd_raddr2, output fwd_hit2, fwd_data2,
      output busy_cnt
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load writeback pipes, with a registered write stage and forwarding.
module rf_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic           clk,
   input logic           reset,
   rf_wb_arbiter_if.slave bus
);
   logic              grant0;
   logic              grant1;
   logic              xfer;
   logic              waiting;
   logic              last_grant;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              we_q;
   logic [ADDR_W-1:0] waddr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [7:0]        busy_q;

   // last_grant names the previous winner; under contention the other side wins.
   always_comb begin
      grant0   = bus.req0_valid && (!bus.req1_valid || last_grant);
      grant1   = bus.req1_valid && (!bus.req0_valid || !last_grant);
      xfer     = grant0 || grant1;
      waiting  = (bus.req0_valid && !grant0) || (bus.req1_valid && !grant1);
      sel_addr = grant1 ? bus.req1_addr : bus.req0_addr;
      sel_data = grant1 ? bus.req1_data : bus.req0_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b1;
         we_q       <= 1'b0;
         waddr_q    <= '0;
         wdata_q    <= '0;
         busy_q     <= '0;
      end else begin
         if (xfer) begin
            last_grant <= grant1;
            // Writes to register 0 are accepted but never reach the file.
            we_q       <= (sel_addr != '0);
            waddr_q    <= sel_addr;
            wdata_q    <= sel_data;
         end else begin
            we_q <= 1'b0;
         end
         if (waiting && (busy_q != '1))
            busy_q <= busy_q + 8'd1;
      end
   end

   assign bus.req0_ready = grant0;
   assign bus.req1_ready = grant1;
   assign bus.rf_we      = we_q;
   assign bus.rf_waddr   = waddr_q;
   assign bus.rf_wdata   = wdata_q;
   assign bus.busy_cnt   = busy_q;

   assign bus.fwd_hit1  = we_q && (waddr_q == bus.fwd_raddr1) && (bus.fwd_raddr1 != '0);
   assign bus.fwd_data1 = bus.fwd_hit1 ? wdata_q : '0;
   assign bus.fwd_hit2  = we_q && (waddr_q == bus.fwd_raddr2) && (bus.fwd_raddr2 != '0);
   assign bus.fwd_data2 = bus.fwd_hit2 ? wdata_q : '0;
endmodule
